// File: rtl/res_scan_ctrl_pkg.sv
// Shared types and constants for the rescaled-result readback sequencer.
// Layer dimensions, index width, FSM states and the layer tag values.
package res_scan_ctrl_pkg;

    localparam int IDX_W    = 12;
    localparam int C_L1_POS = 40;
    localparam int C_L1_CH  = 64;
    localparam int C_L2_N   = 1152;
    localparam int C_L3_POS = 36;
    localparam int C_L3_CH  = 32;

    localparam logic [1:0] L_CONV1 = 2'd1;
    localparam logic [1:0] L_CONV2 = 2'd2;
    localparam logic [1:0] L_CONV3 = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_V,
        S_ISSUE,
        S_WAIT_RD,
        S_PRESENT,
        S_FIN
    } state_t;

    // Position (0..2) of the lowest set bit; only meaningful for a non-zero mask.
    function automatic logic [1:0] lowest_bit(input logic [2:0] m);
        if (m[0]) return 2'd0;
        if (m[1]) return 2'd1;
        return 2'd2;
    endfunction

endpackage

// File: rtl/res_scan_ctrl_if.sv
// Captured-byte output stream: byte, layer tag, flat index, valid/ready.
// The sequencer is the master; the readout sink is the slave.
interface res_scan_ctrl_if;
    import res_scan_ctrl_pkg::*;

    logic [7:0]       dout;
    logic [1:0]       dout_layer;
    logic [IDX_W-1:0] dout_idx;
    logic             dout_valid;
    logic             dout_ready;

    modport master (output dout, dout_layer, dout_idx, dout_valid, input dout_ready);
    modport slave  (input dout, dout_layer, dout_idx, dout_valid, output dout_ready);

endinterface

// File: rtl/res_idx_cnt.sv
// Two-level outer/inner index counter with terminal flag and flat index.
// Registered indices; clr has priority over adv; an inner size of 1 gives a plain counter.
module res_idx_cnt
    import res_scan_ctrl_pkg::*;
#(
    parameter int OUT_N = 40,
    parameter int IN_N  = 64,
    parameter int OUT_W = 6,
    parameter int IN_W  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [OUT_W-1:0] outer,
    output logic [IN_W-1:0]  inner,
    output logic             last,
    output logic [IDX_W-1:0] flat_idx
);

    logic [OUT_W-1:0] outer_q, outer_d;
    logic [IN_W-1:0]  inner_q, inner_d;
    logic             inner_end, outer_end;

    always_comb begin
        inner_end = (inner_q == IN_W'(IN_N - 1));
        outer_end = (outer_q == OUT_W'(OUT_N - 1));
        outer_d   = outer_q;
        inner_d   = inner_q;
        if (clr) begin
            outer_d = '0;
            inner_d = '0;
        end else if (adv) begin
            if (inner_end) begin
                inner_d = '0;
                outer_d = outer_end ? '0 : outer_q + 1'b1;
            end else begin
                inner_d = inner_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outer_q <= '0;
            inner_q <= '0;
        end else begin
            outer_q <= outer_d;
            inner_q <= inner_d;
        end
    end

    assign outer    = outer_q;
    assign inner    = inner_q;
    assign last     = inner_end && outer_end;
    assign flat_idx = IDX_W'(outer_q) * IDX_W'(IN_N) + IDX_W'(inner_q);

endmodule

// File: rtl/res_scan_ctrl.sv
// Walks the result-mux selects of each enabled conv layer and streams the returned bytes.
// One byte per RD_LAT+2 cycles; holds a beat stable in PRESENT until dout_ready.
module res_scan_ctrl
    import res_scan_ctrl_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int L1_POS = C_L1_POS,
    parameter int L1_CH  = C_L1_CH,
    parameter int L2_N   = C_L2_N,
    parameter int L3_POS = C_L3_POS,
    parameter int L3_CH  = C_L3_CH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [2:0]             layer_mask,
    input  logic                   conv1_valid_o_rescaled,
    input  logic                   conv2_valid_o_rescaled,
    input  logic                   conv3_valid_o_rescaled,
    input  logic [7:0]             conv1_res_test,
    input  logic [7:0]             conv2_res_test,
    input  logic [7:0]             conv3_res_test,
    output logic [5:0]             res_sel_1,
    output logic [5:0]             res_sel_1_num,
    output logic [10:0]            res_sel_2,
    output logic [5:0]             res_sel_3,
    output logic [4:0]             res_sel_3_num,
    res_scan_ctrl_if.master        dout_if,
    output logic                   busy,
    output logic                   done
);

    localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t           state_q, state_d;
    logic [2:0]       mask_q, mask_d, pend_q, pend_d;
    logic [1:0]       cur_q, cur_d;
    logic [WC_W-1:0]  wcnt_q, wcnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [7:0]       dout_q, dout_d;
    logic [1:0]       layer_q, layer_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic [2:0]       valid_in, cur_onehot;
    logic             clr_cur, adv_cur, capture;
    logic             last_1, last_2, last_3, cur_last;
    logic [IDX_W-1:0] flat_1, flat_2, flat_3, cur_flat;
    logic [7:0]       cur_byte;
    logic [1:0]       cur_tag;
    logic [0:0]       l2_inner_unused;

    // The counters are the select registers: they move on the edge that enters ISSUE.
    res_idx_cnt #(.OUT_N(L1_POS), .IN_N(L1_CH), .OUT_W(6), .IN_W(6)) u_cnt1 (
        .clk(clk), .rst(rst),
        .clr(clr_cur && cur_q == 2'd0), .adv(adv_cur && cur_q == 2'd0),
        .outer(res_sel_1), .inner(res_sel_1_num), .last(last_1), .flat_idx(flat_1)
    );

    res_idx_cnt #(.OUT_N(L2_N), .IN_N(1), .OUT_W(11), .IN_W(1)) u_cnt2 (
        .clk(clk), .rst(rst),
        .clr(clr_cur && cur_q == 2'd1), .adv(adv_cur && cur_q == 2'd1),
        .outer(res_sel_2), .inner(l2_inner_unused), .last(last_2), .flat_idx(flat_2)
    );

    res_idx_cnt #(.OUT_N(L3_POS), .IN_N(L3_CH), .OUT_W(6), .IN_W(5)) u_cnt3 (
        .clk(clk), .rst(rst),
        .clr(clr_cur && cur_q == 2'd2), .adv(adv_cur && cur_q == 2'd2),
        .outer(res_sel_3), .inner(res_sel_3_num), .last(last_3), .flat_idx(flat_3)
    );

    assign valid_in   = {conv3_valid_o_rescaled, conv2_valid_o_rescaled, conv1_valid_o_rescaled};
    assign cur_onehot = 3'b001 << cur_q;

    always_comb begin
        cur_byte = conv3_res_test;
        cur_flat = flat_3;
        cur_last = last_3;
        cur_tag  = L_CONV3;
        case (cur_q)
            2'd0: begin cur_byte = conv1_res_test; cur_flat = flat_1; cur_last = last_1; cur_tag = L_CONV1; end
            2'd1: begin cur_byte = conv2_res_test; cur_flat = flat_2; cur_last = last_2; cur_tag = L_CONV2; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        pend_d  = busy_q ? (pend_q | valid_in) : pend_q;
        cur_d   = cur_q;
        wcnt_d  = wcnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dout_d  = dout_q;
        layer_d = layer_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        clr_cur = 1'b0;
        adv_cur = 1'b0;
        capture = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mask_d = layer_mask;
                    pend_d = valid_in;
                    if (layer_mask == 3'b000) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        cur_d   = lowest_bit(layer_mask);
                        state_d = S_WAIT_V;
                    end
                end
            end
            S_WAIT_V: begin
                if (|(pend_q & cur_onehot)) begin
                    clr_cur = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (RD_LAT == 0) begin
                    capture = 1'b1;
                end else begin
                    wcnt_d  = '0;
                    state_d = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (wcnt_q == WC_W'(RD_LAT - 1)) capture = 1'b1;
                else                             wcnt_d  = wcnt_q + 1'b1;
            end
            S_PRESENT: begin
                if (dout_if.dout_ready) begin
                    valid_d = 1'b0;
                    if (!cur_last) begin
                        adv_cur = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        mask_d = mask_q & ~cur_onehot;
                        if (mask_d == 3'b000) begin
                            state_d = S_FIN;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            cur_d   = lowest_bit(mask_d);
                            state_d = S_WAIT_V;
                        end
                    end
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            dout_d  = cur_byte;
            layer_d = cur_tag;
            idx_d   = cur_flat;
            valid_d = 1'b1;
            state_d = S_PRESENT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            pend_q  <= '0;
            cur_q   <= '0;
            wcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dout_q  <= '0;
            layer_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            pend_q  <= pend_d;
            cur_q   <= cur_d;
            wcnt_q  <= wcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dout_q  <= dout_d;
            layer_q <= layer_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

    assign dout_if.dout       = dout_q;
    assign dout_if.dout_layer = layer_q;
    assign dout_if.dout_idx   = idx_q;
    assign dout_if.dout_valid = valid_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_res_scan_ctrl.sv
// Directed bench for res_scan_ctrl: registered result-mux model, scenario table, corner sequences.
`timescale 1ns/1ps
module tb_res_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [2:0]  layer_mask;
    logic        v1, v2, v3;
    logic [7:0]  t1, t2, t3;
    logic [5:0]  s1, s1n, s3;
    logic [10:0] s2;
    logic [4:0]  s3n;
    logic        busy, done;

    int tests = 0;
    int fails = 0;

    res_scan_ctrl_if dif();

    res_scan_ctrl #(.RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .layer_mask(layer_mask),
        .conv1_valid_o_rescaled(v1), .conv2_valid_o_rescaled(v2), .conv3_valid_o_rescaled(v3),
        .conv1_res_test(t1), .conv2_res_test(t2), .conv3_res_test(t3),
        .res_sel_1(s1), .res_sel_1_num(s1n), .res_sel_2(s2), .res_sel_3(s3), .res_sel_3_num(s3n),
        .dout_if(dif), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f_byte(input int l, input int idx);
        int v;
        v = idx * 7 + (idx >>> 5) + l * 37;
        return v[7:0];
    endfunction

    // Result mux with one cycle of read latency.
    always @(posedge clk) begin
        t1 <= f_byte(1, int'(s1) * 64 + int'(s1n));
        t2 <= f_byte(2, int'(s2));
        t3 <= f_byte(3, int'(s3) * 32 + int'(s3n));
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int first_layer(input logic [2:0] m);
        for (int b = 0; b < 3; b++) if (m[b]) return b + 1;
        return 0;
    endfunction

    function automatic int layer_size(input int l);
        return (l == 1) ? 2560 : 1152;
    endfunction

    typedef struct {
        logic [2:0] mask;
        logic [2:0] v_start;
        int         v1_cyc, v2_cyc, v3_cyc;
        bit         bp;
        int         exp_n1, exp_n2, exp_n3;
    } scn_t;

    scn_t scn [4];

    task automatic run_scn(input int k, input scn_t s);
        int n1, n2, n3, exp_l, exp_i, cyc, last_hs, sel_act;
        bit stall, fin, exp_done;
        logic rdy;
        logic [2:0] rem;
        logic [7:0] h_d;
        logic [1:0] h_l;
        logic [11:0] h_i;
        logic [10:0] h_s2;
        n1 = 0; n2 = 0; n3 = 0;
        @(negedge clk);
        start = 1'b1; layer_mask = s.mask; {v3, v2, v1} = s.v_start;
        dif.dout_ready = !s.bp;
        @(negedge clk);
        start = 1'b0; {v3, v2, v1} = 3'b000;
        rem = s.mask; exp_l = first_layer(rem); exp_i = 0;
        cyc = 0; last_hs = -1; stall = 0; fin = 0; exp_done = 0;
        h_d = '0; h_l = '0; h_i = '0; h_s2 = '0;
        while (!fin && cyc < 40000) begin
            cyc++;
            v1 = (cyc == s.v1_cyc);
            v2 = (cyc == s.v2_cyc);
            v3 = (cyc == s.v3_cyc);
            if (exp_done) begin
                check($sformatf("scn%0d done pulse {done,busy}", k), {done, busy}, 2'b10);
                fin = 1;
            end else begin
                if (stall)
                    check($sformatf("scn%0d stall hold", k),
                          {dif.dout_valid, dif.dout, dif.dout_layer, dif.dout_idx, s2},
                          {1'b1, h_d, h_l, h_i, h_s2});
                rdy = s.bp ? ($urandom_range(0, 9) < 3) : 1'b1;
                dif.dout_ready = rdy;
                stall = 0;
                if (dif.dout_valid && !rdy) begin
                    stall = 1;
                    h_d = dif.dout; h_l = dif.dout_layer; h_i = dif.dout_idx; h_s2 = s2;
                end else if (dif.dout_valid) begin
                    check($sformatf("scn%0d beat L%0d i%0d {byte,layer,idx}", k, exp_l, exp_i),
                          {dif.dout, dif.dout_layer, dif.dout_idx},
                          {f_byte(exp_l, exp_i), 2'(exp_l), 12'(exp_i)});
                    case (exp_l)
                        1:       sel_act = int'(s1) * 64 + int'(s1n);
                        2:       sel_act = int'(s2);
                        default: sel_act = int'(s3) * 32 + int'(s3n);
                    endcase
                    check($sformatf("scn%0d sel L%0d", k, exp_l), sel_act, exp_i);
                    check($sformatf("scn%0d {busy,done} in dump", k), {busy, done}, 2'b10);
                    if (!s.bp && last_hs >= 0)
                        check($sformatf("scn%0d beat gap i%0d", k, exp_i), cyc - last_hs,
                              (exp_i == 0) ? 4 : 3);
                    last_hs = cyc;
                    case (exp_l)
                        1:       n1++;
                        2:       n2++;
                        default: n3++;
                    endcase
                    if (exp_i == layer_size(exp_l) - 1) begin
                        rem[exp_l-1] = 1'b0;
                        if (rem == 3'b000) exp_done = 1;
                        else begin
                            exp_l = first_layer(rem);
                            exp_i = 0;
                        end
                    end else begin
                        exp_i++;
                    end
                end
            end
            @(negedge clk);
        end
        {v3, v2, v1} = 3'b000;
        check($sformatf("scn%0d reached done", k), fin, 1'b1);
        if (fin) check($sformatf("scn%0d done one cycle", k), done, 1'b0);
        check($sformatf("scn%0d beats L1", k), n1, s.exp_n1);
        check($sformatf("scn%0d beats L2", k), n2, s.exp_n2);
        check($sformatf("scn%0d beats L3", k), n3, s.exp_n3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        scn[0] = '{mask: 3'b001, v_start: 3'b000, v1_cyc: 5, v2_cyc: 0, v3_cyc: 0,
                   bp: 1'b0, exp_n1: 2560, exp_n2: 0, exp_n3: 0};
        scn[1] = '{mask: 3'b111, v_start: 3'b000, v1_cyc: 8, v2_cyc: 30, v3_cyc: 2,
                   bp: 1'b0, exp_n1: 2560, exp_n2: 1152, exp_n3: 1152};
        scn[2] = '{mask: 3'b010, v_start: 3'b000, v1_cyc: 0, v2_cyc: 3, v3_cyc: 0,
                   bp: 1'b1, exp_n1: 0, exp_n2: 1152, exp_n3: 0};
        scn[3] = '{mask: 3'b100, v_start: 3'b100, v1_cyc: 0, v2_cyc: 0, v3_cyc: 0,
                   bp: 1'b0, exp_n1: 0, exp_n2: 0, exp_n3: 1152};

        rst = 1'b1; start = 1'b0; layer_mask = 3'b000;
        v1 = 1'b0; v2 = 1'b0; v3 = 1'b0; dif.dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs",
              {dif.dout, dif.dout_layer, dif.dout_idx, dif.dout_valid, busy, done, s1, s1n, s2, s3, s3n}, 64'd0);
        rst = 1'b0;

        // Empty mask: done on the next cycle, busy never seen.
        @(negedge clk); start = 1'b1; layer_mask = 3'b000;
        @(negedge clk); start = 1'b0;
        check("mask0 {done,busy}", {done, busy}, 2'b10);
        @(negedge clk);
        check("mask0 after {done,busy}", {done, busy}, 2'b00);

        // Valid in IDLE ignored, start while busy ignored, then reset in PRESENT.
        @(negedge clk); v1 = 1'b1;
        @(negedge clk); v1 = 1'b0; start = 1'b1; layer_mask = 3'b001;
        @(negedge clk); start = 1'b0;
        seen = 0;
        repeat (10) begin @(negedge clk); if (dif.dout_valid) seen = 1; end
        check("idle valid ignored {seen,busy}", {seen, busy}, 2'b01);
        start = 1'b1; layer_mask = 3'b010; v2 = 1'b1;
        @(negedge clk); start = 1'b0; v2 = 1'b0;
        seen = 0;
        repeat (10) begin @(negedge clk); if (dif.dout_valid) seen = 1; end
        check("start while busy ignored {seen,busy}", {seen, busy}, 2'b01);
        v1 = 1'b1;
        @(negedge clk); v1 = 1'b0;
        for (int i = 0; i < 10 && !dif.dout_valid; i++) @(negedge clk);
        check("first L1 beat {valid,layer,idx,byte}",
              {dif.dout_valid, dif.dout_layer, dif.dout_idx, dif.dout},
              {1'b1, 2'd1, 12'd0, f_byte(1, 0)});
        @(negedge clk);
        check("L1 beat held without ready", {dif.dout_valid, dif.dout_idx}, {1'b1, 12'd0});
        rst = 1'b1;
        @(negedge clk);
        check("reset mid-scan outputs",
              {dif.dout, dif.dout_layer, dif.dout_idx, dif.dout_valid, busy, done, s1, s1n, s2, s3, s3n}, 64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin @(negedge clk); if (done || busy) seen = 1; end
        check("no done/busy after reset", seen, 1'b0);

        for (int k = 0; k < 4; k++) run_scn(k, scn[k]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
